// File: rtl/bcd_down_timer.sv
// MM:SS countdown timer: four BCD digit stages chained by borrow,
// a prescaler producing decrement ticks, and preset load with per-digit
// saturation. Counting stops at 00:00 with a one-cycle Bo pulse.

// One BCD down-counting digit stage; MAXV is the value it wraps to on borrow.
module bcd_digit #(
  parameter logic [3:0] MAXV = 4'd9
) (
  input  logic [3:0] dig_i,
  input  logic       dec_i,
  output logic [3:0] nxt_o
);
  // decrement with wrap to MAXV when borrowed through zero
  always_comb begin
    nxt_o = dig_i;
    if (dec_i) nxt_o = (dig_i == 4'd0) ? MAXV : dig_i - 4'd1;
  end
endmodule

module bcd_down_timer #(
  parameter int DIV = 100000000,
  parameter int PW  = 27
) (
  input  logic        CP,
  input  logic        _CR,
  input  logic        _LD,
  input  logic [15:0] D,
  input  logic        EN,
  output logic [15:0] Q,
  output logic        Bo,
  output logic        Zero,
  output logic        Tick
);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [15:0]   q_q, q_d;
  logic [PW-1:0] p_q, p_d;
  logic          bo_q, bo_d;
  logic          tick_q, tick_d;

  logic [15:0]   q_dec;   // q_q after one decrement
  logic [15:0]   d_sat;   // preset with digits clamped to BCD time range
  logic [3:0]    brw;     // borrow into each digit (digit 0 always decrements)
  logic          zero;
  logic          run;
  logic          fire;

  assign brw[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_dig
      localparam logic [3:0] MAXV = (i % 2 == 0) ? 4'd9 : 4'd5;
      bcd_digit #(.MAXV(MAXV)) u_dig (
        .dig_i (q_q[4*i +: 4]),
        .dec_i (brw[i]),
        .nxt_o (q_dec[4*i +: 4])
      );
      assign d_sat[4*i +: 4] = (D[4*i +: 4] > MAXV) ? MAXV : D[4*i +: 4];
      if (i < 3) begin : g_brw
        assign brw[i+1] = brw[i] & (q_q[4*i +: 4] == 4'd0);
      end
    end
  endgenerate

  assign zero = (q_q == 16'h0000);
  assign run  = EN & ~zero;
  assign fire = run & (p_q == PMAX);

  // next state: load beats tick; prescaler pinned to 0 once expired
  always_comb begin
    q_d    = q_q;
    p_d    = p_q;
    bo_d   = 1'b0;
    tick_d = 1'b0;
    if (!_LD) begin
      q_d = d_sat;
      p_d = '0;
    end else if (zero) begin
      p_d = '0;
    end else if (run) begin
      p_d = fire ? '0 : p_q + PW'(1);
      if (fire) begin
        q_d    = q_dec;
        tick_d = 1'b1;
        bo_d   = (q_dec == 16'h0000);
      end
    end
  end

  // state registers with synchronous active-low clear
  always_ff @(posedge CP) begin
    if (!_CR) begin
      q_q    <= '0;
      p_q    <= '0;
      bo_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      p_q    <= p_d;
      bo_q   <= bo_d;
      tick_q <= tick_d;
    end
  end

  assign Q    = q_q;
  assign Bo   = bo_q;
  assign Tick = tick_q;
  assign Zero = zero;
endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Synchronous MM:SS countdown timer for the MyClock design, built from four BCD down-counting digit stages chained by borrow.
- Counts down where the 74LS161-style counters count up; a borrow ripples from seconds-ones to minutes-tens, and a terminal borrow marks expiry.
- A loadable preset and a run enable allow countdown alarms. The on-chip prescaler converts the board clock into 1 Hz decrement ticks.

Parameters:
- DIV, 100000000, CP cycles per decrement tick (set to 4 for simulation). Legal range is DIV >= 2.
- PW, 27, prescaler width. Must satisfy 2^PW >= DIV.

Ports:
- CP  in  1  system clock; all state updates on its rising edge.
- _CR  in  1  synchronous clear, active low, sampled on rising CP.
- _LD  in  1  synchronous preset load, active low.
- D  in  16  preset in BCD: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
- EN  in  1  run enable. 1 = count down, 0 = pause.
- Q  out  16  current time, BCD, same packing as D.
- Bo  out  1  registered one-cycle pulse when the count reaches 00:00.
- Zero  out  1  combinational, high while Q == 16'h0000.
- Tick  out  1  registered one-cycle pulse on every decrement tick.

Behaviour:
- Clock and reset: one clock, CP. Reset _CR is synchronous and active-low.
- Priority per rising CP edge: _CR == 0, then _LD == 0, then tick decrement, then hold.
- Clear (_CR == 0):
  - Q = 0, prescaler P = 0, Bo = 0, Tick = 0, therefore Zero = 1.
  - A clear mid-countdown discards the count with no Bo pulse.
- Load (_LD == 0, _CR == 1):
  - Q takes D, with per-digit saturation: ones digits > 9 load as 9, tens digits > 5 load as 5.
  - P = 0. Bo = 0 and Tick = 0 in that cycle.
  - Loading 0000 gives Zero = 1 with no Bo pulse.
  - Load beats a coincident tick; the tick is lost and the prescaler restarts.
- Prescaler:
  - While EN == 1 and Q != 0, P increments each cycle.
  - When P == DIV-1, P wraps to 0 and the tick fires on that edge.
  - While EN == 0, P holds its value. Pausing and resuming does not restart the partial second.
  - While Q == 0, P is held at 0.
- Decrement on tick:
  - sec ones 0 -> 9 and borrows; otherwise -1.
  - sec tens 0 -> 5 and borrows, only when borrowed into; otherwise -1.
  - min ones 0 -> 9 and borrows.
  - min tens -1 when borrowed into.
  - Example: 10:00 -> 09:59.
- Tick output: Tick = 1 for exactly the cycle after each decrement edge.
- Expiry:
  - When a tick moves Q from 0001 to 0000, Bo = 1 for one cycle and the counter stops at 00:00.
  - There is no wrap to 59:59. Further EN has no effect until a load.
- Latency:
  - Q changes on the edge where the tick fires.
  - Bo and Tick are high during the following cycle; they are registered together with Q.
  - Zero follows Q combinationally.
- Q never holds a non-BCD digit and never exceeds 59:59.

Test Plan:
- DIV=4. Hold _CR=0 for 2 cycles, then release with _LD=1, EN=0 -> Q=0000, Zero=1, Bo=0, Tick=0; Q stays 0000 for 10 cycles.
- Load D=16'h0003, EN=1 -> Q steps 0003, 0002, 0001, 0000, one step every 4 cycles; Tick pulses 3 times; Bo is high exactly one cycle after Q becomes 0000; Q holds 0000 for 20 more cycles with no further Bo.
- Load D=16'h1000, run 1 tick -> Q=0959. Load 16'h0100, run 1 tick -> Q=0059. Load 16'h0010, run 1 tick -> Q=0009.
- Load D=16'hFFFF -> Q=5959. Load D=16'h3A7C -> Q=3959.
- Load 0005 with EN=1, drop EN after 2 cycles for 10 cycles, then re-raise it -> the first decrement arrives 2 cycles after EN returns, and Q=0004.
- Load 0002, run, and assert _LD (D=0030) on the same edge the prescaler would tick -> Q=0030, no Tick, P restarts. Then assert _CR=0 mid-count -> Q=0000 and Bo stays 0.
